pipeline_hazard_controller: RTL and testbench

//  Parametrised successor to the fixed stage controller of the 5-stage core (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_controller.sv | 205 ++++++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_controller
//  Description : Stage-advance, flush, forwarding and freeze control for a
//                5-stage pipe, with a memory watchdog and perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FORWARDING_EN  = 1,
    parameter int MEM_TIMEOUT    = 255,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                      id_rs1_used,
    input  logic                      id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_reg_wren,
    input  logic                      ex_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic                      mem_reg_wren,
    input  logic                      mem_branch_taken,
    input  logic                      mem_req,
    input  logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    input  logic                      wb_reg_wren,
    output logic                      pc_wren,
    output logic                      if_id_wren,
    output logic                      id_ex_wren,
    output logic                      ex_mem_wren,
    output logic                      mem_wb_wren,
    output logic                      if_id_flush,
    output logic                      id_ex_flush,
    output logic                      ex_mem_flush,
    output logic                      reg_commit,
    output logic                      ram_commit,
    output logic [1:0]                fwd_rs1_sel,
    output logic [1:0]                fwd_rs2_sel,
    output logic                      halted,
    output logic [CNT_WIDTH-1:0]      stall_cycles,
    output logic [CNT_WIDTH-1:0]      flush_events
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam int                  c_wait_w    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam bit                  c_wdog_en   = (MEM_TIMEOUT != 0);
    localparam bit                  c_fwd_en    = (FORWARDING_EN != 0);

    state_t                state_q, state_d;
    logic [c_wait_w-1:0]   wait_cnt_q, wait_cnt_d;
    logic                  halted_q, halted_d;
    logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_WIDTH-1:0]  flush_events_q, flush_events_d;
    logic [1:0]            fwd_rs1_sel_q, fwd_rs1_sel_d;
    logic [1:0]            fwd_rs2_sel_q, fwd_rs2_sel_d;

    logic w_rs1_live, w_rs2_live;
    logic w_rs1_ex, w_rs1_mem, w_rs1_wb;
    logic w_rs2_ex, w_rs2_mem, w_rs2_wb;
    logic w_raw_stall, w_freeze;

    // Register 0 is hardwired zero, so it never creates a dependency.
    assign w_rs1_live = id_rs1_used && (id_rs1_addr != '0);
    assign w_rs2_live = id_rs2_used && (id_rs2_addr != '0);
    assign w_rs1_ex   = w_rs1_live && ex_reg_wren  && (id_rs1_addr == ex_rd_addr);
    assign w_rs1_mem  = w_rs1_live && mem_reg_wren && (id_rs1_addr == mem_rd_addr);
    assign w_rs1_wb   = w_rs1_live && wb_reg_wren  && (id_rs1_addr == wb_rd_addr);
    assign w_rs2_ex   = w_rs2_live && ex_reg_wren  && (id_rs2_addr == ex_rd_addr);
    assign w_rs2_mem  = w_rs2_live && mem_reg_wren && (id_rs2_addr == mem_rd_addr);
    assign w_rs2_wb   = w_rs2_live && wb_reg_wren  && (id_rs2_addr == wb_rd_addr);
    assign w_freeze   = mem_req && !mem_ready;

    generate
        if (FORWARDING_EN != 0) begin : g_stall_fwd
            assign w_raw_stall = ex_is_load && (w_rs1_ex || w_rs2_ex);
        end else begin : g_stall_nofwd
            assign w_raw_stall = w_rs1_ex || w_rs1_mem || w_rs1_wb ||
                                 w_rs2_ex || w_rs2_mem || w_rs2_wb;
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        halted_d       = halted_q;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        fwd_rs1_sel_d  = fwd_rs1_sel_q;
        fwd_rs2_sel_d  = fwd_rs2_sel_q;
        pc_wren        = 1'b0;
        if_id_wren     = 1'b0;
        id_ex_wren     = 1'b0;
        ex_mem_wren    = 1'b0;
        mem_wb_wren    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        reg_commit     = 1'b0;
        ram_commit     = 1'b0;

        if (reset) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if_id_wren   = 1'b1;
                    id_ex_wren   = 1'b1;
                    ex_mem_wren  = 1'b1;
                    mem_wb_wren  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_d      = ST_RUN;
                end
                ST_RUN, ST_MEM_WAIT: begin
                    if (w_freeze) begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        if (c_wdog_en && (wait_cnt_q == c_wait_last)) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end
                    end else begin
                        state_d     = ST_RUN;
                        wait_cnt_d  = '0;
                        id_ex_wren  = 1'b1;
                        ex_mem_wren = 1'b1;
                        mem_wb_wren = 1'b1;
                        reg_commit  = 1'b1;
                        ram_commit  = 1'b1;
                        if (mem_branch_taken) begin
                            pc_wren      = 1'b1;
                            if_id_wren   = 1'b1;
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                            if (flush_events_q != '1)
                                flush_events_d = flush_events_q + 1'b1;
                        end else if (w_raw_stall) begin
                            id_ex_flush = 1'b1;
                        end else begin
                            pc_wren    = 1'b1;
                            if_id_wren = 1'b1;
                        end
                    end
                    if (!pc_wren && (stall_cycles_q != '1))
                        stall_cycles_d = stall_cycles_q + 1'b1;
                end
                default: ;
            endcase
        end

        // Selection is captured as the ID instruction enters EX, so the
        // current EX writer will sit in MEM and the current MEM writer in WB.
        if (id_ex_wren) begin
            if (id_ex_flush || !c_fwd_en) begin
                fwd_rs1_sel_d = 2'b00;
                fwd_rs2_sel_d = 2'b00;
            end else begin
                fwd_rs1_sel_d = w_rs1_ex ? 2'b01 : (w_rs1_mem ? 2'b10 : 2'b00);
                fwd_rs2_sel_d = w_rs2_ex ? 2'b01 : (w_rs2_mem ? 2'b10 : 2'b00);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT;
            wait_cnt_q     <= '0;
            halted_q       <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
            fwd_rs1_sel_q  <= 2'b00;
            fwd_rs2_sel_q  <= 2'b00;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            halted_q       <= halted_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
            fwd_rs1_sel_q  <= fwd_rs1_sel_d;
            fwd_rs2_sel_q  <= fwd_rs2_sel_d;
        end
    end

    assign fwd_rs1_sel  = fwd_rs1_sel_q;
    assign fwd_rs2_sel  = fwd_rs2_sel_q;
    assign halted       = halted_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_controller
//  Description : Directed bench; dut_a forwards with an 8-cycle watchdog,
//                dut_b has forwarding disabled and the default watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, mem_rd_addr, wb_rd_addr;
    logic       id_rs1_used, id_rs2_used, ex_reg_wren, ex_is_load, mem_reg_wren;
    logic       mem_branch_taken, mem_req, mem_ready, wb_reg_wren;

    logic        pc_a, ifid_a, idex_a, exmem_a, memwb_a, fl_ifid_a, fl_idex_a, fl_exmem_a;
    logic        rc_a, rmc_a, halted_a;
    logic [1:0]  fwd1_a, fwd2_a;
    logic [31:0] stall_a, flushev_a;
    logic        pc_b, ifid_b, idex_b, exmem_b, memwb_b, fl_ifid_b, fl_idex_b, fl_exmem_b;
    logic        rc_b, rmc_b, halted_b;
    logic [1:0]  fwd1_b, fwd2_b;
    logic [31:0] stall_b, flushev_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .FORWARDING_EN(1), .MEM_TIMEOUT(8), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_reg_wren(ex_reg_wren), .ex_is_load(ex_is_load),
        .mem_rd_addr(mem_rd_addr), .mem_reg_wren(mem_reg_wren),
        .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd_addr(wb_rd_addr), .wb_reg_wren(wb_reg_wren),
        .pc_wren(pc_a), .if_id_wren(ifid_a), .id_ex_wren(idex_a),
        .ex_mem_wren(exmem_a), .mem_wb_wren(memwb_a),
        .if_id_flush(fl_ifid_a), .id_ex_flush(fl_idex_a), .ex_mem_flush(fl_exmem_a),
        .reg_commit(rc_a), .ram_commit(rmc_a),
        .fwd_rs1_sel(fwd1_a), .fwd_rs2_sel(fwd2_a), .halted(halted_a),
        .stall_cycles(stall_a), .flush_events(flushev_a)
    );

    pipeline_hazard_controller #(.REG_ADDR_WIDTH(5), .FORWARDING_EN(0), .MEM_TIMEOUT(255), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .reset(reset),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_reg_wren(ex_reg_wren), .ex_is_load(ex_is_load),
        .mem_rd_addr(mem_rd_addr), .mem_reg_wren(mem_reg_wren),
        .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd_addr(wb_rd_addr), .wb_reg_wren(wb_reg_wren),
        .pc_wren(pc_b), .if_id_wren(ifid_b), .id_ex_wren(idex_b),
        .ex_mem_wren(exmem_b), .mem_wb_wren(memwb_b),
        .if_id_flush(fl_ifid_b), .id_ex_flush(fl_idex_b), .ex_mem_flush(fl_exmem_b),
        .reg_commit(rc_b), .ram_commit(rmc_b),
        .fwd_rs1_sel(fwd1_b), .fwd_rs2_sel(fwd2_b), .halted(halted_b),
        .stall_cycles(stall_b), .flush_events(flushev_b)
    );

    logic [4:0] wren_a, wren_b;
    logic [2:0] flush_a, flush_b;
    logic [1:0] commit_a, commit_b;
    assign wren_a   = {pc_a, ifid_a, idex_a, exmem_a, memwb_a};
    assign wren_b   = {pc_b, ifid_b, idex_b, exmem_b, memwb_b};
    assign flush_a  = {fl_ifid_a, fl_idex_a, fl_exmem_a};
    assign flush_b  = {fl_ifid_b, fl_idex_b, fl_exmem_b};
    assign commit_a = {rc_a, rmc_a};
    assign commit_b = {rc_b, rmc_b};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [4:0] wr, input logic [2:0] fl, input logic [1:0] cm);
        check({tag, "_a_wren"}, 64'(wren_a), 64'(wr));
        check({tag, "_a_flush"}, 64'(flush_a), 64'(fl));
        check({tag, "_a_commit"}, 64'(commit_a), 64'(cm));
    endtask

    task automatic chk_b(input string tag, input logic [4:0] wr, input logic [2:0] fl, input logic [1:0] cm);
        check({tag, "_b_wren"}, 64'(wren_b), 64'(wr));
        check({tag, "_b_flush"}, 64'(flush_b), 64'(fl));
        check({tag, "_b_commit"}, 64'(commit_b), 64'(cm));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd_addr = '0; ex_reg_wren = 0; ex_is_load = 0;
        mem_rd_addr = '0; mem_reg_wren = 0; mem_branch_taken = 0;
        mem_req = 0; mem_ready = 0;
        wb_rd_addr = '0; wb_reg_wren = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        chk_a("rst", 5'b00000, 3'b111, 2'b00);
        chk_b("rst", 5'b00000, 3'b111, 2'b00);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_a("init", 5'b01111, 3'b111, 2'b00);
        chk_b("init", 5'b01111, 3'b111, 2'b00);
        check("init_halted", 64'(halted_a), 64'd0);
        check("init_stall", 64'(stall_a), 64'd0);
        check("init_flushev", 64'(flushev_a), 64'd0);
        check("init_fwd1", 64'(fwd1_a), 64'd0);
        step();
        #1;
        chk_a("run", 5'b11111, 3'b000, 2'b11);
        chk_b("run", 5'b11111, 3'b000, 2'b11);
        step();

        // load-use on x5: one bubble, then operand comes from WB
        ex_rd_addr = 5; ex_reg_wren = 1; ex_is_load = 1; id_rs1_addr = 5; id_rs1_used = 1;
        #1;
        chk_a("lu_stall", 5'b00111, 3'b010, 2'b11);
        chk_b("lu_stall", 5'b00111, 3'b010, 2'b11);
        step();
        check("lu_fwd_bubble", 64'(fwd1_a), 64'd0);
        ex_rd_addr = 0; ex_reg_wren = 0; ex_is_load = 0; mem_rd_addr = 5; mem_reg_wren = 1;
        #1;
        chk_a("lu_go", 5'b11111, 3'b000, 2'b11);
        chk_b("lu_mem", 5'b00111, 3'b010, 2'b11);
        step();
        check("lu_fwd1_wb", 64'(fwd1_a), 64'd2);
        check("lu_fwd2", 64'(fwd2_a), 64'd0);
        check("lu_fwd1_b", 64'(fwd1_b), 64'd0);
        idle();
        #1;
        check("lu_stall_cnt_a", 64'(stall_a), 64'd1);
        check("lu_stall_cnt_b", 64'(stall_b), 64'd2);
        step();

        // x0 and unused sources never stall
        ex_rd_addr = 0; ex_reg_wren = 1; ex_is_load = 1; id_rs1_addr = 0; id_rs1_used = 1;
        #1;
        chk_a("x0", 5'b11111, 3'b000, 2'b11);
        chk_b("x0", 5'b11111, 3'b000, 2'b11);
        step();
        idle();
        ex_rd_addr = 3; ex_reg_wren = 1; ex_is_load = 1; id_rs2_addr = 3; id_rs2_used = 0;
        #1;
        chk_a("unused", 5'b11111, 3'b000, 2'b11);
        chk_b("unused", 5'b11111, 3'b000, 2'b11);
        step();

        // ALU producer x6 walks EX -> MEM -> WB while ID reads x6
        idle();
        id_rs1_addr = 6; id_rs1_used = 1; ex_rd_addr = 6; ex_reg_wren = 1;
        #1;
        chk_a("alu_ex", 5'b11111, 3'b000, 2'b11);
        chk_b("alu_ex", 5'b00111, 3'b010, 2'b11);
        step();
        check("alu_fwd1_mem", 64'(fwd1_a), 64'd1);
        ex_rd_addr = 0; ex_reg_wren = 0; mem_rd_addr = 6; mem_reg_wren = 1;
        #1;
        chk_b("alu_mem", 5'b00111, 3'b010, 2'b11);
        step();
        check("alu_fwd1_wb", 64'(fwd1_a), 64'd2);
        mem_rd_addr = 0; mem_reg_wren = 0; wb_rd_addr = 6; wb_reg_wren = 1;
        #1;
        chk_a("alu_wb", 5'b11111, 3'b000, 2'b11);
        chk_b("alu_wb", 5'b00111, 3'b010, 2'b11);
        step();
        check("alu_fwd1_none", 64'(fwd1_a), 64'd0);
        wb_rd_addr = 0; wb_reg_wren = 0;
        #1;
        chk_b("alu_go", 5'b11111, 3'b000, 2'b11);
        check("alu_stall_cnt_a", 64'(stall_a), 64'd1);
        check("alu_stall_cnt_b", 64'(stall_b), 64'd5);
        step();

        // taken branch overrides a concurrent load-use
        idle();
        ex_rd_addr = 5; ex_reg_wren = 1; ex_is_load = 1; id_rs1_addr = 5; id_rs1_used = 1;
        mem_branch_taken = 1;
        #1;
        chk_a("br", 5'b11111, 3'b111, 2'b11);
        chk_b("br", 5'b11111, 3'b111, 2'b11);
        step();
        check("br_flushev_a", 64'(flushev_a), 64'd1);
        check("br_flushev_b", 64'(flushev_b), 64'd1);
        check("br_stall_cnt_a", 64'(stall_a), 64'd1);

        // establish fwd_rs2_sel=01, then freeze 4 cycles (branch ignored)
        idle();
        ex_rd_addr = 7; ex_reg_wren = 1; id_rs2_addr = 7; id_rs2_used = 1;
        #1;
        step();
        check("pre_frz_fwd2", 64'(fwd2_a), 64'd1);
        idle();
        mem_req = 1; mem_ready = 0; mem_branch_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_a($sformatf("frz%0d", i), 5'b00000, 3'b000, 2'b00);
            chk_b($sformatf("frz%0d", i), 5'b00000, 3'b000, 2'b00);
            step();
        end
        check("frz_fwd2_hold", 64'(fwd2_a), 64'd1);
        check("frz_flushev_a", 64'(flushev_a), 64'd1);
        check("frz_stall_cnt_a", 64'(stall_a), 64'd5);
        check("frz_stall_cnt_b", 64'(stall_b), 64'd10);
        mem_branch_taken = 0; mem_ready = 1;
        #1;
        chk_a("release", 5'b11111, 3'b000, 2'b11);
        chk_b("release", 5'b11111, 3'b000, 2'b11);
        step();
        check("release_fwd2", 64'(fwd2_a), 64'd0);

        // watchdog: 8 frozen cycles halts dut_a
        mem_ready = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_a($sformatf("wd%0d", i), 5'b00000, 3'b000, 2'b00);
            if (i == 7) check("wd_not_yet", 64'(halted_a), 64'd0);
            step();
        end
        check("wd_halted_a", 64'(halted_a), 64'd1);
        check("wd_halted_b", 64'(halted_b), 64'd0);
        check("wd_stall_cnt_a", 64'(stall_a), 64'd13);
        mem_ready = 1;
        #1;
        chk_a("halt", 5'b00000, 3'b000, 2'b00);
        chk_b("halt_other", 5'b11111, 3'b000, 2'b11);
        step();
        mem_ready = 0;
        #1;
        step();
        check("halt_stall_frozen", 64'(stall_a), 64'd13);
        check("halt_sticky", 64'(halted_a), 64'd1);
        check("memwait_stall_cnt_b", 64'(stall_b), 64'd19);

        // reset out of HALT (dut_a) and MEM_WAIT (dut_b)
        reset = 1;
        #1;
        chk_a("rst2", 5'b00000, 3'b111, 2'b00);
        chk_b("rst2", 5'b00000, 3'b111, 2'b00);
        step();
        reset = 0;
        idle();
        #1;
        chk_a("init2", 5'b01111, 3'b111, 2'b00);
        chk_b("init2", 5'b01111, 3'b111, 2'b00);
        check("rst2_halted", 64'(halted_a), 64'd0);
        check("rst2_stall_a", 64'(stall_a), 64'd0);
        check("rst2_flushev_a", 64'(flushev_a), 64'd0);
        check("rst2_stall_b", 64'(stall_b), 64'd0);
        check("rst2_flushev_b", 64'(flushev_b), 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
